bcd_digit_converter: RTL

- Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock) feeding the seven_segment_decoder digit inputs.
- Used for scores, counters and frame counts in the VGA demos.
- Latches a binary value on a start pulse, converts over WIDTH clocks, and presents DIGITS registered 4-bit BCD digits with a one-cycle done pulse.
- Sits between game/counter logic and the decoder plus bitmap path.

---
 rtl/bcd_digit_converter_pkg.sv | 16 +
 rtl/bcd_digit_converter_if.sv | 22 ++
 rtl/bcd_digit_converter_add3.sv | 14 +
 rtl/bcd_digit_converter.sv | 112 +++++++++++
 4 files changed

// File: rtl/bcd_digit_converter_pkg.sv
// Shared types and constants for the binary-to-BCD converter slice.
// Latency: none (declarations only).
// Backpressure: not applicable.
package bcd_pkg;

  localparam int DIGIT_W = 4;

  // Nibble value the seven-segment decoder renders as an unlit digit.
  localparam logic [DIGIT_W-1:0] BLANK_DIGIT = 4'hF;

  typedef enum logic {
    IDLE    = 1'b0,
    CONVERT = 1'b1
  } state_t;

endpackage

// File: rtl/bcd_digit_converter_if.sv
// Request/result bundle between counter logic and the BCD converter.
// Latency: none (wires only).
// Backpressure: none; the requester watches busy/done, a start while busy is dropped.
// Ports: start/bin from the master; busy, done, bcd, overflow from the slave.
interface bcd_digit_converter_if
  import bcd_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
);

  logic                      start;
  logic [WIDTH-1:0]          bin;
  logic                      busy;
  logic                      done;
  logic [DIGIT_W*DIGITS-1:0] bcd;
  logic                      overflow;

  modport master (output start, bin, input busy, done, bcd, overflow);
  modport slave  (input start, bin, output busy, done, bcd, overflow);

endinterface

// File: rtl/bcd_digit_converter_add3.sv
// Double-dabble nibble correction: values 5..9 get +3 so the next shift carries.
// Latency: combinational.
// Backpressure: not applicable.
// Ports: din - scratch nibble; dout - corrected nibble (4-bit wrap, no carry out).
module bcd_add3
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] din,
  output logic [DIGIT_W-1:0] dout
);

  assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/bcd_digit_converter.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one input bit per clock).
// Latency: done pulses WIDTH clocks after the edge that accepts start.
// Backpressure: start is only sampled in IDLE; starts while busy are ignored, not queued.
// Ports: clk, reset (sync, active-high); bus.slave carries start/bin in and
//        busy/done/bcd/overflow out, all outputs registered.
// Build option: LEADING_ZERO_BLANK_EN writes leading zero digits (above digit 0)
//        as BLANK_DIGIT unless the value overflowed.
module bcd_digit_converter
  import bcd_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
)(
  input  logic                  clk,
  input  logic                  reset,
  bcd_digit_converter_if.slave  bus
);

  localparam int SCR_W = DIGIT_W * DIGITS;
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t             state;
  logic [WIDTH-1:0]   shift;
  logic [SCR_W-1:0]   scratch;
  logic [SCR_W-1:0]   scratch_adj;
  logic [SCR_W-1:0]   scratch_nxt;
  logic [SCR_W-1:0]   bcd_load;
  logic               ovf;
  logic               ovf_nxt;
  logic [CNT_W-1:0]   count;

  logic               busy_q;
  logic               done_q;
  logic [SCR_W-1:0]   bcd_q;
  logic               overflow_q;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .din  (scratch[g*DIGIT_W +: DIGIT_W]),
      .dout (scratch_adj[g*DIGIT_W +: DIGIT_W])
    );
  end

  // One iteration: corrected scratch shifted left, taking the next binary bit
  // from the top of the shift register. The bit pushed out of scratch means
  // the value no longer fits in DIGITS digits.
  assign scratch_nxt = {scratch_adj[SCR_W-2:0], shift[WIDTH-1]};
  assign ovf_nxt     = ovf | scratch_adj[SCR_W-1];

`ifdef LEADING_ZERO_BLANK_EN
  logic lead;

  // Walk down from the top digit; blank while every digit seen so far is zero.
  always_comb begin
    bcd_load = scratch_nxt;
    lead     = ~ovf_nxt;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (lead && (scratch_nxt[i*DIGIT_W +: DIGIT_W] == '0)) begin
        bcd_load[i*DIGIT_W +: DIGIT_W] = BLANK_DIGIT;
      end else begin
        lead = 1'b0;
      end
    end
  end
`else
  assign bcd_load = scratch_nxt;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      shift      <= '0;
      scratch    <= '0;
      ovf        <= 1'b0;
      count      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      bcd_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state == IDLE) begin
        if (bus.start) begin
          shift   <= bus.bin;
          scratch <= '0;
          ovf     <= 1'b0;
          count   <= '0;
          busy_q  <= 1'b1;
          state   <= CONVERT;
        end
      end else begin
        scratch <= scratch_nxt;
        shift   <= shift << 1;
        ovf     <= ovf_nxt;
        count   <= count + 1'b1;
        if (count == CNT_W'(WIDTH - 1)) begin
          bcd_q      <= bcd_load;
          overflow_q <= ovf_nxt;
          done_q     <= 1'b1;
          busy_q     <= 1'b0;
          state      <= IDLE;
        end
      end
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.bcd      = bcd_q;
  assign bus.overflow = overflow_q;

endmodule
